// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEPTH_DEF     = 64;
  localparam int unsigned BURST_MAX_DEF = 8;

  // Full 32-bit compare so high address bits can never alias into range.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin or fixed priority to port 0, tracking the last winner.
module rr_arbiter2
  import dmem_arb_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_port,
  input  logic force_last1,
  output logic gnt0,
  output logic gnt1
);

  logic rr_last;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (FIXED_PRIO != 0 || rr_last == PORT1) gnt0 = 1'b1;
      else                                     gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rr_last <= PORT1;
    else if (force_last1) rr_last <= PORT1;
    else if (upd)         rr_last <= upd_port;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the pipeline (port 0) and a
// lockable debug/loader master (port 1); registered read responses.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned BURST_MAX  = BURST_MAX_DEF,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_stall,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        addr_err
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  state_t          state;
  logic [CW-1:0]   lock_cnt;
  logic            arb_gnt0, arb_gnt1;
  logic            p0_ok, p1_ok;
  logic            cnt_full;

  assign p0_ok    = addr_in_range(p0_addr, DEPTH);
  assign p1_ok    = addr_in_range(p1_addr, DEPTH);
  // lock_cnt is about to reach BURST_MAX: this is the last held cycle.
  assign cnt_full = (state == LOCK1) && (lock_cnt == CW'(BURST_MAX - 1));

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk        (CLK),
    .rst_n      (rst),
    .req0       (p0_req),
    .req1       (p1_req),
    .upd        (p0_gnt | p1_gnt),
    .upd_port   (p1_gnt ? PORT1 : PORT0),
    .force_last1(cnt_full),
    .gnt0       (arb_gnt0),
    .gnt1       (arb_gnt1)
  );

  always_comb begin
    if (state == LOCK1) begin
      p0_gnt = 1'b0;
      p1_gnt = p1_req;
    end else begin
      p0_gnt = arb_gnt0;
      p1_gnt = arb_gnt1;
    end
  end

  assign p0_stall = p0_req & ~p0_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p1_gnt) begin
      mem_we    = p1_we & p1_ok;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end else if (p0_gnt) begin
      mem_we    = p0_we & p0_ok;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (p1_gnt && p1_lock && BURST_MAX > 1) begin
          state    <= LOCK1;
          lock_cnt <= CW'(1);
        end
        LOCK1: if (!p1_lock || !p1_req || cnt_full) begin
          state    <= IDLE;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
      addr_err  <= 1'b0;
    end else begin
      p0_rvalid <= p0_gnt & ~p0_we;
      p1_rvalid <= p1_gnt & ~p1_we;
      if (p0_gnt && !p0_we) p0_rdata <= p0_ok ? mem_rdata : '0;
      if (p1_gnt && !p1_we) p1_rdata <= p1_ok ? mem_rdata : '0;
      addr_err  <= (p0_gnt & ~p0_ok) | (p1_gnt & ~p1_ok);
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus randomized bench for data_mem_arbiter against a rule-level reference model.
module tb_data_mem_arbiter;

  localparam int unsigned DEPTH     = 64;
  localparam int unsigned BURST_MAX = 8;

  logic        CLK = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, addr_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  data_mem_arbiter #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX), .FIXED_PRIO(0)) dut (
    .CLK(CLK), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .addr_err(addr_err)
  );

  // Environment memory: async read, sync write.
  logic [31:0] mem [DEPTH];
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;
  always @(posedge CLK) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  bit          m_lock;
  int          m_held, m_last, mg;
  logic        e_rv0, e_rv1, e_err;
  logic [31:0] e_rd0, e_rd1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_held = 0; m_last = 1;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rd0 = '0; e_rd1 = '0;
  endtask

  function automatic int model_grant();
    if (m_lock) return p1_req ? 1 : -1;
    if (p0_req && p1_req) return (m_last == 0) ? 1 : 0;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  task automatic settle();
    logic [31:0] a, d;
    logic w;
    #1;
    mg = model_grant();
    a = '0; d = '0; w = 1'b0;
    if (mg == 0) begin a = p0_addr; d = p0_wdata; w = p0_we && (p0_addr < DEPTH); end
    if (mg == 1) begin a = p1_addr; d = p1_wdata; w = p1_we && (p1_addr < DEPTH); end
    chk("p0_gnt", 32'(p0_gnt), 32'(mg == 0));
    chk("p1_gnt", 32'(p1_gnt), 32'(mg == 1));
    chk("p0_stall", 32'(p0_stall), 32'(p0_req && mg != 0));
    chk("mem_we", 32'(mem_we), 32'(w));
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
  endtask

  task automatic edge_step();
    logic [31:0] a, d;
    logic w, ok;
    @(posedge CLK);
    #1;
    a = (mg == 1) ? p1_addr : p0_addr;
    d = (mg == 1) ? p1_wdata : p0_wdata;
    w = (mg == 1) ? p1_we : p0_we;
    ok = a < DEPTH;
    e_rv0 = (mg == 0) && !w;
    e_rv1 = (mg == 1) && !w;
    if (e_rv0) e_rd0 = ok ? ref_mem[a[5:0]] : 32'h0;
    if (e_rv1) e_rd1 = ok ? ref_mem[a[5:0]] : 32'h0;
    e_err = (mg >= 0) && !ok;
    if (mg >= 0 && w && ok) ref_mem[a[5:0]] = d;
    if (mg >= 0) m_last = mg;
    if (m_lock) begin
      m_held++;
      if (m_held == BURST_MAX) begin m_lock = 1'b0; m_last = 1; end
      else if (!p1_lock || !p1_req) m_lock = 1'b0;
    end else if (mg == 1 && p1_lock) begin
      m_lock = 1'b1; m_held = 1;
    end
    chk("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
    chk("p0_rdata", p0_rdata, e_rd0);
    chk("p1_rdata", p1_rdata, e_rd1);
    chk("addr_err", 32'(addr_err), 32'(e_err));
    @(negedge CLK);
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
  endtask

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return 32'(DEPTH) + ($urandom & 32'h7FFF_FFFF);
    return 32'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    int stall_run, first_p0;
    logic [31:0] saved;
    for (int i = 0; i < DEPTH; i++) begin
      saved = $urandom;
      mem[i] = saved;
      ref_mem[i] = saved;
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    model_reset();

    rst = 1'b1;
    #2 rst = 1'b0;
    #4;
    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    @(negedge CLK);
    rst = 1'b1;

    // p0 read of word 5, p1 idle
    drive(1, 0, 32'd5, '0, 0, 0, '0, '0, 0);
    settle();
    chk("rd5_gnt", 32'(p0_gnt), 32'd1);
    chk("rd5_stall", 32'(p0_stall), 32'd0);
    edge_step();
    chk("rd5_rvalid", 32'(p0_rvalid), 32'd1);
    chk("rd5_rdata", p0_rdata, 32'hDEAD_BEEF);

    // both requesting: p0 just won, so p1 leads the alternation
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'(i), '0, 1, 0, 32'(20 + i), '0, 0);
      settle();
      chk("alt_p1_gnt", 32'(p1_gnt), 32'(i % 2 == 0));
      chk("alt_stall", 32'(p0_stall), 32'(i % 2 == 0));
      edge_step();
    end

    // p1 locked write burst against a continuously requesting p0
    stall_run = 0;
    first_p0 = -1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 32'd1, '0, 1, 1, 32'(10 + i), $urandom, 1);
      settle();
      if (first_p0 < 0) begin
        if (p0_gnt) first_p0 = i;
        else if (p0_stall) stall_run++;
      end
      edge_step();
    end
    chk("burst_stall_cycles", 32'(stall_run), 32'd8);
    chk("burst_first_p0", 32'(first_p0), 32'd8);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    cycle();

    // store then load of the same word
    drive(1, 1, 32'd3, 32'h1234_5678, 0, 0, '0, '0, 0);
    cycle();
    drive(1, 0, 32'd3, '0, 0, 0, '0, '0, 0);
    cycle();
    chk("raw_rvalid", 32'(p0_rvalid), 32'd1);
    chk("raw_rdata", p0_rdata, 32'h1234_5678);

    // out-of-range store and load
    saved = mem[0];
    drive(1, 1, 32'd64, 32'hCAFE_F00D, 0, 0, '0, '0, 0);
    settle();
    chk("oor_mem_we", 32'(mem_we), 32'd0);
    edge_step();
    chk("oor_wr_err", 32'(addr_err), 32'd1);
    chk("oor_mem0", mem[0], saved);
    drive(1, 0, 32'hFFFF_FFFF, '0, 0, 0, '0, '0, 0);
    cycle();
    chk("oor_rd_data", p0_rdata, 32'd0);
    chk("oor_rd_err", 32'(addr_err), 32'd1);

    // reset while p1 holds a lock with a read response pending
    drive(0, 0, '0, '0, 1, 0, 32'd7, '0, 1);
    cycle();
    cycle();
    chk("lock_rvalid", 32'(p1_rvalid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(p1_rvalid), 32'd0);
    chk("mid_rst_rdata", p1_rdata, 32'd0);
    model_reset();
    drive(1, 0, 32'd9, '0, 1, 0, 32'd11, '0, 0);
    @(negedge CLK);
    rst = 1'b1;
    settle();
    chk("post_rst_p0_first", 32'(p0_gnt), 32'd1);
    edge_step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            $urandom_range(0, 9) < 7);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (async read, sync write, DEPTH words, word-indexed) between two requesters.
- Port 0 is the pipeline MEM stage (lw/sw). Port 1 is the debug/loader master, which may lock the memory for bursts.
- Grants one requester per cycle, muxes address, write data and write enable to the memory, and returns registered read data.
- Produces a stall for the pipeline when port 0 loses arbitration.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory; legal addresses are 0..DEPTH-1.
- BURST_MAX, 8, maximum consecutive cycles port 1 may hold a lock before a forced release.
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins unless port 1 holds a lock.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- p0_req  in  1  pipeline access request.
- p0_we  in  1  pipeline write (sw) when 1, read (lw) when 0.
- p0_addr  in  32  pipeline word address (ALU result).
- p0_wdata  in  32  pipeline store data.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_stall  out  1  p0_req and not p0_gnt; holds the pipeline.
- p0_rvalid  out  1  registered read-data valid, one cycle after a granted read.
- p0_rdata  out  32  registered read data.
- p1_req, p1_we, p1_addr[31:0], p1_wdata[31:0]  in  same meaning for port 1.
- p1_lock  in  1  request to keep ownership on following cycles.
- p1_gnt, p1_rvalid, p1_rdata[31:0]  out  same meaning for port 1.
- mem_we  out  1  write enable to the data memory.
- mem_addr  out  32  address to the data memory.
- mem_wdata  out  32  write data to the data memory.
- mem_rdata  in  32  asynchronous read data from the data memory.
- addr_err  out  1  registered pulse: the previous granted access was out of range.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, rr_last=1 (port 0 wins the first tie), lock_cnt=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0, addr_err=0.
- States: IDLE (no lock) and LOCK1 (port 1 owns the memory).
- Arbitration in IDLE, combinational:
  - Only one port requesting: that port is granted.
  - Both requesting, FIXED_PRIO=1: port 0 is granted.
  - Both requesting, FIXED_PRIO=0: the port not equal to rr_last is granted.
  - rr_last updates to the granted port at the clock edge.
- In LOCK1: p1_gnt = p1_req; p0_gnt=0.
- IDLE->LOCK1: at a clock edge where p1 is granted and p1_lock=1; lock_cnt is set to 1.
- In LOCK1, lock_cnt increments every cycle.
- LOCK1->IDLE when any of the following holds:
  - p1_lock=0;
  - p1_req=0;
  - lock_cnt reaches BURST_MAX. On this forced release, rr_last=1 so port 0 wins the next tie.
- Memory mux: granted port drives mem_addr and mem_wdata; mem_we = granted port's we and addr_ok.
- No grant: mem_we=0, mem_addr=0, mem_wdata=0.
- addr_ok means addr < DEPTH, computed on the full 32-bit compare.
- Reads:
  - On a granted read, at the clock edge, px_rdata is loaded with mem_rdata if addr_ok, else 0, and px_rvalid=1 for exactly one cycle.
  - px_rdata holds its value when px_rvalid=0.
- Writes: committed by the memory at the same edge; no rvalid.
- addr_err is a 1-cycle pulse after any granted access with addr >= DEPTH. The write is suppressed and read data is 0.
- Simultaneous write then read of the same address on consecutive grants: the read returns the new data (memory write precedes the async read).
- Reset asserted mid-lock: returns to IDLE immediately; any pending rvalid is cleared.
- p0_stall is purely combinational. The pipeline must hold p0_addr, p0_wdata and p0_we stable while stalled.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding: IDLE=1'b0, LOCK1=1'b1;
  - port index constants: PORT0=1'b0, PORT1=1'b1;
  - default DEPTH and BURST_MAX.
- One natural sub-module: rr_arbiter2, the 2-way round-robin/fixed-priority grant logic holding rr_last.
- The FSM, lock counter, mux and response registers stay in the top module.

Test Plan:
- Reset, then p0 read addr 5 with memory word 5 = 32'hDEADBEEF, p1 idle -> p0_gnt=1 same cycle, p0_stall=0; next cycle p0_rvalid=1, p0_rdata=32'hDEADBEEF.
- Both request every cycle, FIXED_PRIO=0, no lock -> grants alternate p0,p1,p0,p1; p0_stall=1 on the p1 cycles.
- p1 writes addr 10..17 with p1_lock=1 for 12 cycles, BURST_MAX=8, p0 requesting throughout:
  - p1 holds the memory for 8 cycles;
  - forced release, then p0 granted;
  - p0_stall=1 for exactly 8 cycles.
- p0 sw addr 3 = 32'h12345678, next cycle p0 lw addr 3 -> p0_rdata=32'h12345678 one cycle later.
- p0 sw addr 64 (DEPTH=64) -> mem_we=0, addr_err pulse next cycle, memory unchanged; p0 lw addr 32'hFFFFFFFF -> p0_rdata=0, addr_err=1.
- Assert rst during LOCK1 with p1_rvalid pending -> state IDLE, p1_rvalid=0, p1_rdata=0 immediately; after release, a p0 request is granted first.
